spike_encoder: RTL
==================

SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 1, giving the number of independent spike channels.
REQ-002 SHALL have parameter COUNTER_SIZE, default 4, giving the count width; one frame = 2**COUNTER_SIZE timesteps.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset (0 = reset).
REQ-005 SHALL have port load_valid  input  1  count_in holds a valid frame request.
REQ-006 SHALL have port load_ready  output  1  encoder can accept a request.
REQ-007 SHALL have port count_in  input  unpacked array [NUM_INPUTS-1:0] of [COUNTER_SIZE-1:0]  spikes requested per channel per frame, same shape as a spike-counter output.
REQ-008 SHALL have port step_en  input  1  advance one timestep this cycle.
REQ-009 SHALL have port spike_out  output  NUM_INPUTS  registered one-cycle spike pulses.
REQ-010 SHALL have port busy  output  1  frame in progress.
REQ-011 SHALL have port frame_done  output  1  one-cycle end-of-frame pulse.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 In IDLE: load_ready=1, busy=0, step_en ignored, spike_out=0.
REQ-014 On load_valid&&load_ready: capture count_in per channel, clear every accumulator and the step counter, go to RUN.
REQ-015 In RUN/DONE: load_ready=0, busy=1, load_valid ignored with no capture.
REQ-016 Each RUN cycle with step_en=1, per channel i: acc[i] <= (acc[i]+count[i]) mod 2**COUNTER_SIZE; spike_out[i] <= carry-out of that addition; step counter increments.
REQ-017 In a RUN cycle with step_en=0, spike_out SHALL be 0 and acc, count, step counter SHALL hold.
REQ-018 Latency: the spike for a step SHALL appear on spike_out in the cycle after the step_en cycle.
REQ-019 Over one frame, channel i SHALL emit exactly count[i] spikes: 0 gives none; 2**COUNTER_SIZE-1 gives spikes on every step except the first.
REQ-020 Accumulator and step counter SHALL wrap modulo 2**COUNTER_SIZE with no saturation or overflow flag.
REQ-021 The step_en cycle taking the step counter from 2**COUNTER_SIZE-1 to 0 SHALL move RUN to DONE.
REQ-022 In DONE: frame_done=1, coincident with the last step's spike_out; next cycle go to IDLE unconditionally.
REQ-023 A request can be accepted at the earliest in the IDLE cycle after DONE; back-to-back frames are separated by exactly one DONE cycle.

Reset
REQ-024 rst=0 SHALL immediately, without waiting for clk, force state IDLE and spike_out=0, busy=0, frame_done=0, acc=0, count=0, step counter=0; load_ready=1 while rst=0.
REQ-025 Reset mid-frame SHALL abandon the frame with no further spikes or frame_done; the next load SHALL start a fresh frame.

Structure
REQ-026 The FSM state enum type and any frame-length constant derived from COUNTER_SIZE SHALL live in the shared SNN package.
REQ-027 Each channel's count register, accumulator and carry logic SHALL be one sub-module, rate_accumulator, instantiated NUM_INPUTS times in a generate loop; spike_encoder keeps the FSM and step counter.

Verification
REQ-028 NUM_INPUTS=2, COUNTER_SIZE=4, load {5,0}, step_en=1 constantly -> ch0 exactly 5 spikes, ch1 none, frame_done one pulse 17 cycles after the handshake cycle.
REQ-029 count=8 -> spikes after steps 2,4,...,16 (8 total); count=15 -> 15 spikes, none after step 1.
REQ-030 step_en toggling 1/0 each cycle, count=5 -> 5 spikes, frame spans 32 cycles, spike_out=0 in every cycle following a step_en=0 cycle.
REQ-031 load_valid held high with new count_in during RUN -> no capture, load_ready=0, frame result unchanged.
REQ-032 rst=0 after step 7 -> spike_out/busy drop to 0 and load_ready rises without a clock edge; reload with 3 -> exactly 3 spikes in the new frame.
REQ-033 Loopback: spike_out feeds a per-channel spike counter, random counts over 20 frames -> counter value equals the loaded count every frame.

Source files
------------

// File: rtl/spike_encoder_pkg.sv
// Shared SNN definitions: encoder FSM states and frame-length helpers
// derived from the counter width.
package spike_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

  // Number of timesteps in one frame for a given count width.
  function automatic int unsigned frame_len(input int unsigned counter_size);
    return 32'd1 << counter_size;
  endfunction

  // Step-counter value of the final timestep of a frame.
  function automatic int unsigned last_step(input int unsigned counter_size);
    return frame_len(counter_size) - 32'd1;
  endfunction

endpackage

// File: rtl/rate_accumulator.sv
// One spike channel: holds the requested count, accumulates it once per step
// and emits the carry-out as a registered spike pulse.
module rate_accumulator #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_c,
  input  logic         step_c,
  input  logic [W-1:0] count_in,
  output logic         spike_out
);

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] acc_q, acc_d;
  logic         spike_q, spike_d;
  logic [W:0]   sum;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, count_q};
    count_d = count_q;
    acc_d   = acc_q;
    spike_d = 1'b0;
    if (load_c) begin
      count_d = count_in;
      acc_d   = '0;
    end else if (step_c) begin
      // Modulo wrap of the accumulator; the carry is the spike.
      acc_d   = sum[W-1:0];
      spike_d = sum[W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      acc_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      count_q <= count_d;
      acc_q   <= acc_d;
      spike_q <= spike_d;
    end
  end

  assign spike_out = spike_q;

endmodule

// File: rtl/spike_encoder.sv
// Rate-coded spike encoder: accepts a per-channel count, then over one frame
// of 2**COUNTER_SIZE steps emits exactly that many spikes per channel.
module spike_encoder
  import spike_encoder_pkg::*;
#(
  parameter int unsigned NUM_INPUTS   = 1,
  parameter int unsigned COUNTER_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [COUNTER_SIZE-1:0] count_in [NUM_INPUTS-1:0],
  input  logic                    step_en,
  output logic [NUM_INPUTS-1:0]   spike_out,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int unsigned CW = COUNTER_SIZE;
  localparam logic [CW-1:0] LAST_STEP = CW'(last_step(COUNTER_SIZE));

  enc_state_e    state_q, state_d;
  logic [CW-1:0] step_cnt_q, step_cnt_d;
  logic          load_ready_q, load_ready_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          load_c;
  logic          step_c;

  // Next-state, step counter and channel control.
  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    load_c     = 1'b0;
    step_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          load_c     = 1'b1;
          step_cnt_d = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (step_en) begin
          step_c     = 1'b1;
          step_cnt_d = step_cnt_q + CW'(1);
          if (step_cnt_q == LAST_STEP) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Status outputs are registered copies of the next-state decode.
    load_ready_d = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      step_cnt_q   <= '0;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_cnt_q   <= step_cnt_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_ch
    rate_accumulator #(
      .W (CW)
    ) u_acc (
      .clk       (clk),
      .rst       (rst),
      .load_c    (load_c),
      .step_c    (step_c),
      .count_in  (count_in[g]),
      .spike_out (spike_out[g])
    );
  end

endmodule
